// File: rtl/frame_stream_reader_pkg.sv
// Shared constants and FSM encoding for the frame stream reader.
package frame_stream_reader_pkg;

  localparam int W               = 64;
  localparam int H               = 64;
  localparam int TOTAL_PIXEL     = W * H;
  localparam int TOTAL_PIXEL_BIT = $clog2(TOTAL_PIXEL);
  localparam int PIX_W           = 8;
  localparam int COL_W           = (W > 1) ? $clog2(W) : 1;
  localparam int ROW_W           = (H > 1) ? $clog2(H) : 1;

  localparam logic [TOTAL_PIXEL_BIT:0] LAST_ISSUE = (TOTAL_PIXEL_BIT + 1)'(TOTAL_PIXEL - 1);
  localparam logic [COL_W-1:0]         COL_LAST   = COL_W'(W - 1);
  localparam logic [ROW_W-1:0]         ROW_LAST   = ROW_W'(H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO absorbing RAM read returns ahead of the output handshake.
module stream_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic [1:0]    occ_o,
  output logic          empty_o
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    occ_q;
  logic [1:0]    occ_d;

  assign occ_d = occ_q + {1'b0, push_i} - {1'b0, pop_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;
  assign empty_o = (occ_q == 2'd0);

endmodule

// File: rtl/frame_stream_reader.sv
// Streams a finished frame out of the result RAM in raster order with
// valid/ready handshake and sof/eol/eof markers.
module frame_stream_reader
  import frame_stream_reader_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [TOTAL_PIXEL_BIT-1:0] rd_addr,
  input  logic [PIX_W-1:0]           rd_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [PIX_W-1:0]           m_data,
  output logic                       m_sof,
  output logic                       m_eol,
  output logic                       m_eof
);

  state_t                     state_q, state_d;
  logic [TOTAL_PIXEL_BIT-1:0] rd_addr_q, rd_addr_d;
  logic [TOTAL_PIXEL_BIT:0]   issue_cnt_q, issue_cnt_d;
  logic                       inflight_q;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [COL_W-1:0]           col_q, col_d;
  logic [ROW_W-1:0]           row_q, row_d;

  logic       issue;
  logic       pop;
  logic       fifo_empty;
  logic [1:0] occ;
  logic [2:0] credit_sum;
  logic       credit_ok;
  logic       at_eol;
  logic       at_eof;

  assign pop        = m_valid & m_ready;
  assign at_eol     = (col_q == COL_LAST);
  assign at_eof     = at_eol && (row_q == ROW_LAST);
  // Entries held plus the one still returning must leave room for a new read.
  assign credit_sum = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
  assign credit_ok  = (credit_sum < 3'd2);

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    issue_cnt_d = issue_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    col_d       = col_q;
    row_d       = row_q;
    issue       = 1'b0;

    if (pop) begin
      if (at_eol) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          rd_addr_d   = '0;
          issue_cnt_d = '0;
          busy_d      = 1'b1;
          col_d       = '0;
          row_d       = '0;
        end
      end
      RUN: begin
        if (credit_ok) begin
          issue       = 1'b1;
          issue_cnt_d = issue_cnt_q + 1'b1;
          // The address stays parked on the last pixel once it is issued.
          if (issue_cnt_q == LAST_ISSUE) begin
            state_d = DRAIN;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pop && at_eof) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      issue_cnt_q <= '0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      issue_cnt_q <= issue_cnt_d;
      inflight_q  <= issue;
      busy_q      <= busy_d;
      done_q      <= done_d;
      col_q       <= col_d;
      row_q       <= row_d;
    end
  end

  stream_fifo2 #(.DW(PIX_W)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (rd_data),
    .pop_i       (pop),
    .head_o      (m_data),
    .occ_o       (occ),
    .empty_o     (fifo_empty)
  );

  assign m_valid = ~fifo_empty;
  assign m_sof   = m_valid && (col_q == '0) && (row_q == '0);
  assign m_eol   = m_valid && at_eol;
  assign m_eof   = m_valid && at_eof;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_frame_stream_reader.sv
// Directed bench: RAM model with pixel[a] = a[7:0] ^ 8'h5A, beat monitor, per-scenario tasks.
module tb_frame_stream_reader;

  localparam int TP = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [11:0] rd_addr;
  logic [7:0]  rd_data = 8'h00;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic        m_sof;
  logic        m_eol;
  logic        m_eof;

  int checks = 0;
  int errors = 0;

  frame_stream_reader dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_sof   (m_sof),
    .m_eol   (m_eol),
    .m_eof   (m_eof)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [TP];
  initial begin
    for (int a = 0; a < TP; a++) mem[a] = 8'(a) ^ 8'h5A;
  end
  always @(posedge clk) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Beat monitor: records handshakes and flags data/marker/stall/address problems.
  int         frame_idx = 0;
  int         mon_bad = 0;
  int         stall_bad = 0;
  int         stall_cycles = 0;
  int         occ_bad = 0;
  int         addr_bad = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  bit         done_busy = 1'b0;
  int         frame_beats = 0;
  int         first_cyc = 0;
  int         last_cyc = 0;
  bit         prev_stall = 1'b0;
  logic [10:0] prev_out = '0;
  logic [11:0] prev_addr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      frame_idx  = 0;
      prev_stall = 1'b0;
      prev_addr  = '0;
    end else begin
      if (start && !busy) frame_idx = 0;
      if (dut.u_fifo.occ_q > 2'd2) occ_bad++;
      if (rd_addr != prev_addr && rd_addr != prev_addr + 12'd1 && rd_addr != 12'd0) addr_bad++;
      prev_addr = rd_addr;
      if (prev_stall && (!m_valid || {m_data, m_sof, m_eol, m_eof} !== prev_out)) stall_bad++;
      if (m_valid && m_ready) begin
        if (m_data !== (8'(frame_idx) ^ 8'h5A) || m_sof !== (frame_idx == 0) ||
            m_eol !== (frame_idx % 64 == 63) || m_eof !== (frame_idx == TP - 1)) mon_bad++;
        if (frame_idx == 0) first_cyc = cyc;
        if (frame_idx == TP - 1) last_cyc = cyc;
        frame_idx++;
      end
      prev_stall = m_valid && !m_ready;
      if (prev_stall) stall_cycles++;
      prev_out = {m_data, m_sof, m_eol, m_eof};
      if (done) begin
        done_cnt++;
        done_cyc    = cyc;
        done_busy   = busy;
        frame_beats = frame_idx;
      end
    end
  end

  task automatic wait_done(input int budget, output bit ok);
    int base;
    base = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_beat(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_idx == idx) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, m_valid, m_sof, m_eol, m_eof, m_data, rd_addr} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {busy, done, m_valid, m_sof, m_eol, m_eof, m_data, rd_addr});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, m_valid, rd_addr} !== 14'd0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b valid=%b addr=%0d required 0", busy, m_valid, rd_addr);
    end
    $display("test_reset: done");
  endtask

  task automatic test_full_frame;
    int bad0;
    bit ok;
    bad0 = mon_bad;
    m_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: valid after edge1 = %b required 0", m_valid);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || busy !== 1'b1 || m_sof !== 1'b1) begin
      errors++;
      $display("FAIL latency_first: valid=%b busy=%b sof=%b required 1 1 1", m_valid, busy, m_sof);
    end
    wait_done(6000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_timeout: done not seen, required within 6000 cycles");
    end
    checks++;
    if (last_cyc - first_cyc !== TP - 1) begin
      errors++;
      $display("FAIL full_throughput: span %0d required %0d", last_cyc - first_cyc, TP - 1);
    end
    checks++;
    if (done_cyc !== last_cyc + 1 || done_busy !== 1'b0) begin
      errors++;
      $display("FAIL full_done_timing: done_cyc=%0d busy=%b required %0d 0", done_cyc, done_busy, last_cyc + 1);
    end
    checks++;
    if (frame_beats !== TP || mon_bad !== bad0) begin
      errors++;
      $display("FAIL full_stream: beats=%0d bad=%0d required %0d 0", frame_beats, mon_bad - bad0, TP);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: done=%b required 0", done);
    end
    $display("test_full_frame: beats=%0d", frame_beats);
  endtask

  task automatic test_random_ready;
    int bad0, st0, sc0, oc0, ad0, dn0;
    logic [15:0] lfsr;
    lfsr = 16'hACE1;
    bad0 = mon_bad; st0 = stall_bad; sc0 = stall_cycles; oc0 = occ_bad; ad0 = addr_bad; dn0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 20000 && done_cnt == dn0; i++) begin
      @(posedge clk); #1;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      m_ready = lfsr[0];
    end
    @(negedge clk);
    m_ready = 1'b1;
    checks++;
    if (done_cnt == dn0) begin
      errors++;
      $display("FAIL random_timeout: done not seen, required within 20000 cycles");
    end
    checks++;
    if (frame_beats !== TP || mon_bad !== bad0) begin
      errors++;
      $display("FAIL random_stream: beats=%0d bad=%0d required %0d 0", frame_beats, mon_bad - bad0, TP);
    end
    checks++;
    if (stall_bad !== st0 || stall_cycles == sc0) begin
      errors++;
      $display("FAIL random_stall_stable: unstable=%0d stalls=%0d required 0 and >0", stall_bad - st0, stall_cycles - sc0);
    end
    checks++;
    if (occ_bad !== oc0 || addr_bad !== ad0) begin
      errors++;
      $display("FAIL random_occ_addr: overflow=%0d addr_skips=%0d required 0 0", occ_bad - oc0, addr_bad - ad0);
    end
    $display("test_random_ready: beats=%0d stalls=%0d", frame_beats, stall_cycles - sc0);
  endtask

  task automatic test_backpressure;
    int bad0, held_bad;
    bit ok;
    bad0 = mon_bad;
    held_bad = 0;
    m_ready = 1'b0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_first_valid: valid not seen, required within 20 cycles");
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b1 || m_data !== 8'h5A || m_sof !== 1'b1) held_bad++;
    end
    checks++;
    if (held_bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d bad cycles (last valid=%b data=%h) required 0", held_bad, m_valid, m_data);
    end
    checks++;
    if (rd_addr > 12'd2) begin
      errors++;
      $display("FAIL bp_addr_stop: rd_addr=%0d required <=2", rd_addr);
    end
    @(posedge clk); #1 m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h5B || m_sof !== 1'b0) begin
      errors++;
      $display("FAIL bp_resume: valid=%b data=%h sof=%b required 1 5b 0", m_valid, m_data, m_sof);
    end
    wait_done(6000, ok);
    checks++;
    if (!ok || frame_beats !== TP || mon_bad !== bad0) begin
      errors++;
      $display("FAIL bp_stream: done=%b beats=%0d bad=%0d required 1 %0d 0", ok, frame_beats, mon_bad - bad0, TP);
    end
    $display("test_backpressure: beats=%0d", frame_beats);
  endtask

  task automatic test_second_start;
    int dn0, extra;
    bit ok;
    dn0 = done_cnt;
    extra = 0;
    m_ready = 1'b1;
    pulse_start();
    wait_beat(1000, 2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL second_start_reach: beat index %0d required 1000", frame_idx);
    end
    pulse_start();
    wait_done(6000, ok);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_valid || busy || done) extra++;
    end
    checks++;
    if (!ok || frame_beats !== TP || done_cnt - dn0 !== 1 || extra != 0) begin
      errors++;
      $display("FAIL second_start_ignored: beats=%0d dones=%0d extra=%0d required %0d 1 0", frame_beats, done_cnt - dn0, extra, TP);
    end
    $display("test_second_start: beats=%0d dones=%0d", frame_beats, done_cnt - dn0);
  endtask

  task automatic test_reset_midframe;
    int dn0, bad0;
    bit ok;
    m_ready = 1'b1;
    pulse_start();
    wait_beat(2000, 3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midreset_reach: beat index %0d required 2000", frame_idx);
    end
    dn0 = done_cnt;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, m_valid, m_sof, m_eol, m_eof, m_data, rd_addr} !== 26'd0) begin
      errors++;
      $display("FAIL midreset_async: got %h required 0", {busy, done, m_valid, m_sof, m_eol, m_eof, m_data, rd_addr});
    end
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt !== dn0 || m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet: dones=%0d valid=%b busy=%b required 0 0 0", done_cnt - dn0, m_valid, busy);
    end
    bad0 = mon_bad;
    pulse_start();
    wait_done(6000, ok);
    checks++;
    if (!ok || frame_beats !== TP || mon_bad !== bad0) begin
      errors++;
      $display("FAIL midreset_restart: done=%b beats=%0d bad=%0d required 1 %0d 0", ok, frame_beats, mon_bad - bad0, TP);
    end
    $display("test_reset_midframe: restart beats=%0d", frame_beats);
  endtask

  task automatic test_back_to_back;
    int dn0, bad0;
    bit ok;
    dn0 = done_cnt;
    bad0 = mon_bad;
    m_ready = 1'b1;
    pulse_start();
    wait_done(6000, ok);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: valid after edge1 = %b required 0", m_valid);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_sof !== 1'b1 || m_data !== 8'h5A) begin
      errors++;
      $display("FAIL b2b_first: valid=%b sof=%b data=%h required 1 1 5a", m_valid, m_sof, m_data);
    end
    wait_done(6000, ok);
    checks++;
    if (!ok || frame_beats !== TP || mon_bad !== bad0 || done_cnt - dn0 !== 2) begin
      errors++;
      $display("FAIL b2b_stream: beats=%0d bad=%0d dones=%0d required %0d 0 2", frame_beats, mon_bad - bad0, done_cnt - dn0, TP);
    end
    $display("test_back_to_back: beats=%0d dones=%0d", frame_beats, done_cnt - dn0);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_random_ready();
    test_backpressure();
    test_second_start();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_stream_reader.md
Name: frame_stream_reader

Overview:
- Reads a finished W x H 8-bit frame out of the histogram result RAM through its synchronous read port (rd_addr/rd_data, 1-cycle read latency).
- Emits the frame as a raster-order pixel stream with a valid/ready handshake and frame/line markers.
- Sits outside the histogram top, driving its external rd_addr and consuming its rd_data.
- Started by software or by the top-level done pulse; fully backpressure-safe.

Parameters:
- W, 64, frame width in pixels
- H, 64, frame height in pixels
- TOTAL_PIXEL, W*H, pixels per frame
- TOTAL_PIXEL_BIT, $clog2(W*H), RAM address width

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  pulse; begin streaming one frame
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last beat is accepted
- rd_addr  out  TOTAL_PIXEL_BIT  address to result RAM
- rd_data  in  8  RAM data; valid the cycle after the corresponding address
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts the beat
- m_data  out  8  pixel value
- m_sof  out  1  beat is pixel 0 (start of frame)
- m_eol  out  1  beat is the last pixel of a row (column W-1)
- m_eof  out  1  beat is pixel TOTAL_PIXEL-1

Behaviour:
- Reset (async assert, sync deassert): all outputs 0; FSM to IDLE; 2-entry buffer empty; counters 0.
- FSM states:
  - IDLE: start=1 -> RUN, rd_addr<=0, busy<=1.
  - RUN: issue reads; after address TOTAL_PIXEL-1 has been issued -> DRAIN.
  - DRAIN: no new issues; when the eof beat handshakes -> IDLE with done=1 for one cycle and busy<=0.
- Issue rule:
  - A read issues in a cycle where rd_addr holds the next address and (occ - pop + inflight) < 2.
    - occ: buffer occupancy, 0..2.
    - pop: m_valid & m_ready.
    - inflight: 1 if a read was issued the previous cycle.
  - rd_addr increments only on issue. It holds its value when stalled and after the last issue.
  - Returned data is written into the buffer the cycle after issue.
  - The buffer never overflows; the bench asserts on overflow.
- Output:
  - m_valid = buffer not empty; m_data is the head entry.
  - m_data and all markers hold stable while m_valid & !m_ready.
  - Markers are derived from output-side col (0..W-1) and row (0..H-1) counters, which advance on pop.
  - m_eof = (row==H-1 && col==W-1).
- Latency: with start sampled at edge 0 and m_ready=1, first m_valid is high in the cycle after edge 2. Throughput is then 1 beat/cycle, so a frame takes TOTAL_PIXEL consecutive valid cycles.
- Backpressure: holding m_ready low stops issuing within 2 beats. No data is lost or duplicated, and the order is exact raster.
- start while busy: ignored, with no effect on counters. start on the same cycle as done (in DRAIN): ignored. A new frame needs start in IDLE.
- Reset mid-frame: immediate return to IDLE, buffer flushed, no done pulse.
- Width rules:
  - rd_addr wraps never; the issue counter is TOTAL_PIXEL_BIT+1 wide to detect end.
  - col and row widths are $clog2(W) and $clog2(H), minimum 1.

Decomposition:
- Shared package: W, H, TOTAL_PIXEL, TOTAL_PIXEL_BIT, PIX_W=8, and the FSM state encoding (IDLE, RUN, DRAIN).
- Sub-module stream_fifo2: 2-entry, 8+3 bit (data plus markers optional) FIFO with push/pop/occ. The parent only tracks issue credit.

Test Plan:
- RAM preloaded with pixel[a]=a[7:0]^8'h5A; start, m_ready=1 -> 4096 beats in 4096 consecutive cycles starting 3 edges after start; data matches; m_sof on beat 0; m_eol on beats 63,127,...,4095; m_eof only on beat 4095; done 1 cycle after beat 4095; busy falls with done.
- Random m_ready (50% duty, fixed seed) -> identical 4096-value sequence; m_data and markers stable under stall; buffer never exceeds 2; rd_addr monotonic without skips.
- m_ready=0 for 100 cycles after first beat -> m_valid held with data 8'h5A; rd_addr stops at 2 or less; on release the stream resumes with 8'h5B.
- Second start pulse at beat 1000 -> ignored; single frame of exactly 4096 beats, one done pulse.
- rst_n low for 2 cycles at beat 2000 -> all outputs 0 asynchronously, no done pulse; a subsequent start streams a full, correct frame from pixel 0 with m_sof.
- Back-to-back: start in the cycle after done -> second frame identical; no gap artefacts; m_sof on its first beat.
